// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access size codes, FSM states and
// the alignment rule used both at capture time and on the registered slot.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Size code 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr[0];
      default: mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data RAM: store byte enables and replicated write
// data, load lane extraction with sign/zero extension, and the misalign flag.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wr_data,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be       = 4'b0000;
    wr_data  = st_data;
    ld_data  = rd_word;
    misalign = is_misaligned(size, addr);
    lane_b   = 8'h00;
    lane_h   = addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (addr)
      2'd0:    lane_b = rd_word[7:0];
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase

    // Write data is replicated across lanes so the enables alone pick the target.
    case (size)
      SZ_B: begin
        be      = 4'b0001 << addr;
        wr_data = {4{st_data[7:0]}};
        ld_data = {{24{sext & lane_b[7]}}, lane_b};
      end
      SZ_H: begin
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{st_data[15:0]}};
        ld_data = {{16{sext & lane_h[15]}}, lane_h};
      end
      default: be = 4'b1111;
    endcase
  end

endmodule

// File: rtl/mem_stage_be.sv
// MEM stage: EX/MEM register, byte-enabled data RAM, wait-state stall FSM and
// branch resolution. States: ST_IDLE | slot free, capture each cycle; ST_BUSY | access in progress, hold slot.
module mem_stage_be
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2,
  parameter int TAG_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_destR,
  input  logic [DATA_W-1:0] ex_inB,
  input  logic [DATA_W-1:0] ex_aluR,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic              ex_wmem,
  input  logic [1:0]        ex_size,
  input  logic              ex_sext,
  input  logic              ex_branch,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic              flush,
  input  logic [TAG_W-1:0]  EXE_ins_type,
  input  logic [TAG_W-1:0]  EXE_ins_number,
  output logic              mem_stall,
  output logic              mem_valid,
  output logic              mem_wreg,
  output logic              mem_m2reg,
  output logic [DATA_W-1:0] mem_mdata,
  output logic [DATA_W-1:0] mem_aluR,
  output logic [4:0]        mem_destR,
  output logic [DATA_W-1:0] mem_pc,
  output logic              mem_branch,
  output logic              mem_misalign,
  output logic [TAG_W-1:0]  MEM_ins_type,
  output logic [TAG_W-1:0]  MEM_ins_number
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYC > 2) ? $clog2(WAIT_CYC) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] slot_inB;
  logic              slot_wreg, slot_wmem, slot_sext, slot_branch, slot_zero;
  logic [1:0]        slot_size;

  logic              cap_memop;
  logic [3:0]        be;
  logic [DATA_W-1:0] wr_data, rd_word;
  logic              lane_mis, slot_memop, st_commit;

  logic [DATA_W-1:0] ram [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_destR      <= '0;
      slot_inB       <= '0;
      mem_aluR       <= '0;
      slot_wreg      <= 1'b0;
      mem_m2reg      <= 1'b0;
      slot_wmem      <= 1'b0;
      slot_size      <= SZ_B;
      slot_sext      <= 1'b0;
      slot_branch    <= 1'b0;
      slot_zero      <= 1'b0;
      mem_pc         <= '0;
      MEM_ins_type   <= '0;
      MEM_ins_number <= '0;
    end else if (!mem_stall) begin
      mem_destR   <= ex_destR;
      slot_inB    <= ex_inB;
      mem_aluR    <= ex_aluR;
      slot_size   <= ex_size;
      slot_sext   <= ex_sext;
      slot_zero   <= ex_zero;
      mem_pc      <= ex_pc;
      mem_valid   <= ex_valid & ~flush;
      slot_wreg   <= ex_wreg & ~flush;
      mem_m2reg   <= ex_m2reg & ~flush;
      slot_wmem   <= ex_wmem & ~flush;
      slot_branch <= ex_branch & ~flush;
      MEM_ins_type   <= flush ? '0 : EXE_ins_type;
      MEM_ins_number <= flush ? '0 : EXE_ins_number;
    end
  end

  // The stall FSM only looks at what is being captured, so alignment is checked on the ex_* side too.
  assign cap_memop = ex_valid & ~flush & (ex_wmem | ex_m2reg) & ~is_misaligned(ex_size, ex_aluR[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_memop && WAIT_CYC > 0) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(WAIT_CYC - 1);
        end
      end
      default: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
  end

  assign mem_stall = (state_q == ST_BUSY);

  mem_align u_align (
    .addr     (mem_aluR[1:0]),
    .size     (slot_size),
    .sext     (slot_sext),
    .st_data  (slot_inB),
    .rd_word  (rd_word),
    .be       (be),
    .wr_data  (wr_data),
    .ld_data  (mem_mdata),
    .misalign (lane_mis)
  );

  assign slot_memop   = mem_valid & (slot_wmem | mem_m2reg);
  assign mem_misalign = slot_memop & lane_mis;
  assign mem_wreg     = mem_valid & slot_wreg & ~mem_misalign;
  assign mem_branch   = mem_valid & slot_branch & slot_zero;

  // The slot is replaced on every unstalled edge, so this fires exactly once per store.
  assign st_commit = mem_valid & slot_wmem & ~mem_misalign & ~mem_stall;

  assign rd_word = ram[mem_aluR[ADDR_W+1:2]];

  always_ff @(posedge clk) begin
    if (st_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[mem_aluR[ADDR_W+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_be.sv
// Directed bench for mem_stage_be with WAIT_CYC=2: stall length, load/store
// lanes, misalignment, branch/flush, stall hold and reset during an access.
module tb_mem_stage_be;
  import mem_pkg::*;

  localparam int DATA_W = 32, ADDR_W = 8, WAIT_CYC = 2, TAG_W = 4;

  logic              clk, rst;
  logic              ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_sext, ex_branch, ex_zero, flush;
  logic [4:0]        ex_destR;
  logic [DATA_W-1:0] ex_inB, ex_aluR, ex_pc;
  logic [1:0]        ex_size;
  logic [TAG_W-1:0]  EXE_ins_type, EXE_ins_number;
  logic              mem_stall, mem_valid, mem_wreg, mem_m2reg, mem_branch, mem_misalign;
  logic [DATA_W-1:0] mem_mdata, mem_aluR, mem_pc;
  logic [4:0]        mem_destR;
  logic [TAG_W-1:0]  MEM_ins_type, MEM_ins_number;

  int tests, fails;

  mem_stage_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_destR(ex_destR), .ex_inB(ex_inB),
    .ex_aluR(ex_aluR), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_size(ex_size), .ex_sext(ex_sext), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_pc(ex_pc), .flush(flush), .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
    .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_mdata(mem_mdata), .mem_aluR(mem_aluR), .mem_destR(mem_destR), .mem_pc(mem_pc),
    .mem_branch(mem_branch), .mem_misalign(mem_misalign), .MEM_ins_type(MEM_ins_type),
    .MEM_ins_number(MEM_ins_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_nop();
    ex_valid = 0; ex_destR = 0; ex_inB = 0; ex_aluR = 0; ex_wreg = 0; ex_m2reg = 0; ex_wmem = 0;
    ex_size = SZ_W; ex_sext = 0; ex_branch = 0; ex_zero = 0; ex_pc = 0; flush = 0;
    EXE_ins_type = 0; EXE_ins_number = 0;
  endtask

  task automatic mem_op(input logic st, input logic [1:0] sz, input logic sx, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] dest, input logic [3:0] tag);
    set_nop();
    ex_valid = 1; ex_wmem = st; ex_m2reg = !st; ex_wreg = !st; ex_size = sz; ex_sext = sx;
    ex_aluR = addr; ex_inB = data; ex_destR = dest;
    EXE_ins_type = st ? 4'h2 : 4'h1; EXE_ins_number = tag;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Capture whatever is on ex_* and return how many cycles the stall lasted.
  task automatic run_op(output int n);
    tick();
    n = 0;
    while (mem_stall && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    tests++; if ({mem_valid, mem_stall, mem_wreg, mem_m2reg, mem_branch, mem_misalign} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 000000", {mem_valid, mem_stall, mem_wreg, mem_m2reg, mem_branch, mem_misalign}); end
    tests++; if ({mem_aluR, mem_pc, mem_destR} !== 69'b0) begin
      fails++; $display("FAIL reset_fields: got aluR=%h pc=%h dest=%h expected 0", mem_aluR, mem_pc, mem_destR); end
    tests++; if ({MEM_ins_type, MEM_ins_number} !== 8'h00) begin
      fails++; $display("FAIL reset_tags: got %h expected 00", {MEM_ins_type, MEM_ins_number}); end
  endtask

  task automatic test_back_to_back();
    int n;
    mem_op(1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 0, 4'h1);
    run_op(n);
    tests++; if (n !== 2) begin fails++; $display("FAIL sw_stall_len: got %0d expected 2", n); end
    mem_op(0, SZ_W, 0, 32'h10, 0, 5'd7, 4'h2);
    run_op(n);
    tests++; if (n !== 2) begin fails++; $display("FAIL lw_stall_len: got %0d expected 2", n); end
    tests++; if (mem_mdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data: got %h expected deadbeef", mem_mdata); end
    tests++; if ({mem_valid, mem_wreg, mem_m2reg, mem_destR, MEM_ins_number} !== {3'b111, 5'd7, 4'h2}) begin
      fails++; $display("FAIL lw_ctrl: got v=%b w=%b m=%b d=%0d n=%h expected 1 1 1 7 2", mem_valid, mem_wreg, mem_m2reg, mem_destR, MEM_ins_number); end
    mem_op(0, SZ_W, 0, 32'h410, 0, 5'd8, 4'h3);
    run_op(n);
    tests++; if (mem_mdata !== 32'hDEADBEEF) begin fails++; $display("FAIL addr_wrap: got %h expected deadbeef", mem_mdata); end
  endtask

  task automatic test_byte();
    int n;
    mem_op(1, SZ_W, 0, 32'h20, 32'h11223344, 0, 4'h4); run_op(n);
    mem_op(1, SZ_B, 0, 32'h21, 32'hAABBCC80, 0, 4'h5); run_op(n);
    mem_op(0, SZ_W, 0, 32'h20, 0, 5'd1, 4'h6); run_op(n);
    tests++; if (mem_mdata !== 32'h11228044) begin fails++; $display("FAIL sb_lanes: got %h expected 11228044", mem_mdata); end
    mem_op(0, SZ_B, 1, 32'h21, 0, 5'd1, 4'h7); run_op(n);
    tests++; if (mem_mdata !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_sext: got %h expected ffffff80", mem_mdata); end
    mem_op(0, SZ_B, 0, 32'h21, 0, 5'd1, 4'h8); run_op(n);
    tests++; if (mem_mdata !== 32'h00000080) begin fails++; $display("FAIL lbu: got %h expected 00000080", mem_mdata); end
    mem_op(0, SZ_B, 1, 32'h23, 0, 5'd1, 4'h9); run_op(n);
    tests++; if (mem_mdata !== 32'h00000011) begin fails++; $display("FAIL lb_pos: got %h expected 00000011", mem_mdata); end
  endtask

  task automatic test_misalign();
    int n;
    mem_op(1, SZ_W, 0, 32'h30, 32'hCAFEF00D, 0, 4'h1); run_op(n);
    mem_op(1, SZ_H, 0, 32'h33, 32'h0000BEEF, 0, 4'h2); tick();
    tests++; if ({mem_misalign, mem_stall, mem_valid} !== 3'b101) begin
      fails++; $display("FAIL sh_misalign: got mis=%b stall=%b v=%b expected 1 0 1", mem_misalign, mem_stall, mem_valid); end
    mem_op(0, SZ_W, 0, 32'h32, 0, 5'd4, 4'h3); tick();
    tests++; if ({mem_misalign, mem_wreg, mem_stall} !== 3'b100) begin
      fails++; $display("FAIL lw_misalign: got mis=%b wreg=%b stall=%b expected 1 0 0", mem_misalign, mem_wreg, mem_stall); end
    mem_op(0, SZ_W, 0, 32'h30, 0, 5'd4, 4'h4); run_op(n);
    tests++; if ({mem_mdata, mem_misalign} !== {32'hCAFEF00D, 1'b0}) begin
      fails++; $display("FAIL misalign_ram: got %h mis=%b expected cafef00d 0", mem_mdata, mem_misalign); end
    mem_op(0, SZ_H, 1, 32'h32, 0, 5'd4, 4'h5); run_op(n);
    tests++; if (mem_mdata !== 32'hFFFFCAFE) begin fails++; $display("FAIL lh_sext: got %h expected ffffcafe", mem_mdata); end
    mem_op(0, SZ_H, 0, 32'h30, 0, 5'd4, 4'h6); run_op(n);
    tests++; if (mem_mdata !== 32'h0000F00D) begin fails++; $display("FAIL lhu: got %h expected 0000f00d", mem_mdata); end
  endtask

  task automatic test_branch_flush();
    set_nop();
    ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_pc = 32'h1234; ex_aluR = 32'h3;
    EXE_ins_type = 4'hA; EXE_ins_number = 4'h6;
    tick();
    tests++; if ({mem_branch, mem_valid, mem_misalign, mem_stall} !== 4'b1100) begin
      fails++; $display("FAIL br_taken: got br=%b v=%b mis=%b stall=%b expected 1 1 0 0", mem_branch, mem_valid, mem_misalign, mem_stall); end
    tests++; if ({mem_pc, MEM_ins_type} !== {32'h1234, 4'hA}) begin
      fails++; $display("FAIL br_target: got pc=%h type=%h expected 1234 a", mem_pc, MEM_ins_type); end
    ex_zero = 0; tick();
    tests++; if (mem_branch !== 1'b0) begin fails++; $display("FAIL br_not_taken: got %b expected 0", mem_branch); end
    ex_zero = 1; flush = 1; tick();
    tests++; if ({mem_branch, mem_valid, MEM_ins_type, MEM_ins_number} !== 10'b0) begin
      fails++; $display("FAIL br_flush: got br=%b v=%b tags=%h%h expected 0 0 00", mem_branch, mem_valid, MEM_ins_type, MEM_ins_number); end
    set_nop(); tick();
  endtask

  task automatic test_stall_hold();
    mem_op(0, SZ_W, 0, 32'h20, 0, 5'd9, 4'h5);
    tick();
    ex_aluR = 32'h44; ex_destR = 5'd3; flush = 1; EXE_ins_number = 4'hF;
    tick();
    tests++; if ({mem_stall, mem_valid, mem_aluR, mem_destR, MEM_ins_number} !== {2'b11, 32'h20, 5'd9, 4'h5}) begin
      fails++; $display("FAIL hold_busy: got s=%b v=%b a=%h d=%0d n=%h expected 1 1 20 9 5", mem_stall, mem_valid, mem_aluR, mem_destR, MEM_ins_number); end
    tick();
    tests++; if ({mem_stall, mem_valid, mem_aluR, mem_destR, MEM_ins_number} !== {2'b01, 32'h20, 5'd9, 4'h5}) begin
      fails++; $display("FAIL hold_release: got s=%b v=%b a=%h d=%0d n=%h expected 0 1 20 9 5", mem_stall, mem_valid, mem_aluR, mem_destR, MEM_ins_number); end
    tests++; if (mem_mdata !== 32'h11228044) begin fails++; $display("FAIL hold_data: got %h expected 11228044", mem_mdata); end
    set_nop(); tick();
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL hold_next: got %b expected 0", mem_valid); end
  endtask

  task automatic test_reset_busy();
    int n;
    mem_op(1, SZ_W, 0, 32'h40, 32'hA5A5A5A5, 0, 4'h1); run_op(n);
    mem_op(1, SZ_W, 0, 32'h40, 32'h12345678, 0, 4'h2); tick();
    tests++; if (mem_stall !== 1'b1) begin fails++; $display("FAIL rb_busy: got %b expected 1", mem_stall); end
    #2 rst = 1;
    #1;
    tests++; if ({mem_valid, mem_stall, mem_wreg, mem_branch, mem_misalign, mem_aluR, MEM_ins_type, MEM_ins_number} !== 45'b0) begin
      fails++; $display("FAIL rb_clear: got v=%b s=%b a=%h tags=%h%h expected all 0", mem_valid, mem_stall, mem_aluR, MEM_ins_type, MEM_ins_number); end
    set_nop();
    @(negedge clk) rst = 0;
    tick();
    tests++; if ({mem_stall, mem_valid} !== 2'b00) begin fails++; $display("FAIL rb_after: got s=%b v=%b expected 0 0", mem_stall, mem_valid); end
    mem_op(0, SZ_W, 0, 32'h40, 0, 5'd2, 4'h3); run_op(n);
    tests++; if (mem_mdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL rb_ram: got %h expected a5a5a5a5", mem_mdata); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1;
    set_nop();
    #3;
    test_reset();
    @(negedge clk) rst = 0;
    tick();
    test_back_to_back();
    test_byte();
    test_misalign();
    test_branch_flush();
    test_stall_hold();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
